// File: rtl/ncu_sii_pkt_rcv.sv
// NCU-side receiver for SII->NCU packets: request counting, grants, 1+4 cycle capture, parity check, packet FIFO.
// Optional NCU_SII_PERR_DROP_EN: drop packets with payload parity errors and count them in perr_drop_cnt.
module ncu_sii_pkt_rcv #(
    parameter int DEPTH      = 4,
    parameter int REQ_CNT_W  = 4,
    parameter int GNT_TO_HDR = 2
) (
    input  logic          iol2clk,
    input  logic          rst,
    input  logic          sii_ncu_req,
    input  logic [31:0]   sii_ncu_data,
    input  logic [1:0]    sii_ncu_dparity,
    output logic          ncu_sii_gnt,
    output logic          pkt_vld,
    input  logic          pkt_rdy,
    output logic [31:0]   pkt_hdr,
    output logic [127:0]  pkt_payload,
    output logic          pkt_perr,
    output logic          req_ovf
`ifdef NCU_SII_PERR_DROP_EN
    ,
    output logic [15:0]   perr_drop_cnt
`endif
);
    localparam int AW  = $clog2(DEPTH);
    localparam int OW  = AW + 1;
    localparam int WCW = $clog2(GNT_TO_HDR + 1);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'((GNT_TO_HDR > 1) ? (GNT_TO_HDR - 2) : 0);

    typedef enum logic [2:0] {
        ST_IDLE, ST_GNT, ST_WAIT, ST_HDR, ST_PL0, ST_PL1, ST_PL2, ST_PL3
    } state_t;

    // Per-half even parity mismatch flags: [1] upper 16 bits, [0] lower 16 bits.
    function automatic logic [1:0] par_err(input logic [31:0] d, input logic [1:0] p);
        return {(^d[31:16]) ^ p[1], (^d[15:0]) ^ p[0]};
    endfunction

    state_t              state_r;
    logic [WCW-1:0]      wait_cnt_r;
    logic [REQ_CNT_W-1:0] req_cnt_r;
    logic [31:0]         hdr_r;
    logic [95:0]         pl_r;
    logic                perr_acc_r;
    logic [AW-1:0]       wr_ptr_r, rd_ptr_r;
    logic [OW-1:0]       occ_r;
    logic [31:0]         mem_hdr [DEPTH];
    logic [127:0]        mem_pl  [DEPTH];

    logic cur_perr_s, pkt_perr_s, space_s, go_gnt_s, push_s, pop_s;

    assign cur_perr_s = |par_err(sii_ncu_data, sii_ncu_dparity);
    assign pkt_perr_s = perr_acc_r | cur_perr_s;
    // The packet between grant and PL3 already owns a slot, so it counts against free space.
    assign space_s    = (occ_r + OW'(state_r != ST_IDLE)) < OW'(DEPTH);
    assign go_gnt_s   = ((req_cnt_r != {REQ_CNT_W{1'b0}}) || sii_ncu_req) && space_s;
    assign pkt_vld    = (occ_r != {OW{1'b0}});
    assign pop_s      = pkt_vld && pkt_rdy;
`ifdef NCU_SII_PERR_DROP_EN
    assign push_s     = (state_r == ST_PL3) && !pkt_perr_s;
    assign pkt_perr   = 1'b0;
`else
    logic mem_perr [DEPTH];
    assign push_s     = (state_r == ST_PL3);
    assign pkt_perr   = pkt_vld & mem_perr[rd_ptr_r];
`endif
    assign pkt_hdr     = pkt_vld ? mem_hdr[rd_ptr_r] : 32'h0;
    assign pkt_payload = pkt_vld ? mem_pl[rd_ptr_r]  : 128'h0;

    // Transfer sequencer: grant, header delay, header and payload capture.
    always_ff @(posedge iol2clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            ncu_sii_gnt <= 1'b0;
            wait_cnt_r  <= {WCW{1'b0}};
            hdr_r       <= 32'h0;
            pl_r        <= 96'h0;
            perr_acc_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (go_gnt_s) begin
                        state_r     <= ST_GNT;
                        ncu_sii_gnt <= 1'b1;
                    end
                end
                ST_GNT: begin
                    ncu_sii_gnt <= 1'b0;
                    wait_cnt_r  <= {WCW{1'b0}};
                    state_r     <= (GNT_TO_HDR > 1) ? ST_WAIT : ST_HDR;
                end
                ST_WAIT: begin
                    if (wait_cnt_r == WAIT_LAST) state_r <= ST_HDR;
                    else wait_cnt_r <= wait_cnt_r + WCW'(1);
                end
                ST_HDR: begin
                    hdr_r      <= sii_ncu_data;
                    perr_acc_r <= 1'b0;
                    state_r    <= ST_PL0;
                end
                ST_PL0: begin
                    pl_r[31:0] <= sii_ncu_data;
                    perr_acc_r <= perr_acc_r | cur_perr_s;
                    state_r    <= ST_PL1;
                end
                ST_PL1: begin
                    pl_r[63:32] <= sii_ncu_data;
                    perr_acc_r  <= perr_acc_r | cur_perr_s;
                    state_r     <= ST_PL2;
                end
                ST_PL2: begin
                    pl_r[95:64] <= sii_ncu_data;
                    perr_acc_r  <= perr_acc_r | cur_perr_s;
                    state_r     <= ST_PL3;
                end
                ST_PL3: begin
                    if (go_gnt_s) begin
                        state_r     <= ST_GNT;
                        ncu_sii_gnt <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    ncu_sii_gnt <= 1'b0;
                end
            endcase
        end
    end

    // Outstanding-request counter; saturates at all-ones and flags the overflow stickily.
    always_ff @(posedge iol2clk or posedge rst) begin
        if (rst) begin
            req_cnt_r <= {REQ_CNT_W{1'b0}};
            req_ovf   <= 1'b0;
        end else if (sii_ncu_req && !ncu_sii_gnt) begin
            if (req_cnt_r == {REQ_CNT_W{1'b1}}) req_ovf <= 1'b1;
            else req_cnt_r <= req_cnt_r + REQ_CNT_W'(1);
        end else if (!sii_ncu_req && ncu_sii_gnt) begin
            req_cnt_r <= req_cnt_r - REQ_CNT_W'(1);
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge iol2clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            occ_r    <= {OW{1'b0}};
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
            if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
            if (push_s && !pop_s) occ_r <= occ_r + OW'(1);
            else if (!push_s && pop_s) occ_r <= occ_r - OW'(1);
        end
    end

    // FIFO storage; contents are only observed through the pkt_vld gate.
    always_ff @(posedge iol2clk) begin
        if (push_s) begin
            mem_hdr[wr_ptr_r] <= hdr_r;
            mem_pl[wr_ptr_r]  <= {sii_ncu_data, pl_r};
`ifndef NCU_SII_PERR_DROP_EN
            mem_perr[wr_ptr_r] <= pkt_perr_s;
`endif
        end
    end

`ifdef NCU_SII_PERR_DROP_EN
    // Saturating count of packets discarded for payload parity errors.
    always_ff @(posedge iol2clk or posedge rst) begin
        if (rst) perr_drop_cnt <= 16'h0;
        else if ((state_r == ST_PL3) && pkt_perr_s && (perr_drop_cnt != 16'hFFFF))
            perr_drop_cnt <= perr_drop_cnt + 16'h1;
    end
`endif
endmodule

// File: tb/tb_ncu_sii_pkt_rcv.sv
// Directed self-checking bench for ncu_sii_pkt_rcv (DEPTH=4, REQ_CNT_W=4, GNT_TO_HDR=2).
module tb_ncu_sii_pkt_rcv;
    localparam int DEPTH = 4;
    localparam int REQ_CNT_W = 4;
    localparam int G2H = 2;

    logic         iol2clk = 1'b0;
    logic         rst, sii_ncu_req, pkt_rdy;
    logic [31:0]  sii_ncu_data;
    logic [1:0]   sii_ncu_dparity;
    logic         ncu_sii_gnt, pkt_vld, pkt_perr, req_ovf;
    logic [31:0]  pkt_hdr;
    logic [127:0] pkt_payload;
`ifdef NCU_SII_PERR_DROP_EN
    logic [15:0]  perr_drop_cnt;
`endif

    int n_pass = 0;
    int n_fail = 0;
    int n_checks = 0;
    int cyc = 0;
    int gnt_seen = 0;
    int gnt_cyc [64];
    int flip_pkt = -1;
    int flip_sel = 0;
    logic [1:0] flip_mask = 2'b00;

    typedef struct {
        logic [31:0]  hdr;
        logic [127:0] pl;
        logic         perr;
    } pop_t;
    pop_t popped [$];

    ncu_sii_pkt_rcv #(.DEPTH(DEPTH), .REQ_CNT_W(REQ_CNT_W), .GNT_TO_HDR(G2H)) dut (
        .iol2clk(iol2clk), .rst(rst), .sii_ncu_req(sii_ncu_req),
        .sii_ncu_data(sii_ncu_data), .sii_ncu_dparity(sii_ncu_dparity),
        .ncu_sii_gnt(ncu_sii_gnt), .pkt_vld(pkt_vld), .pkt_rdy(pkt_rdy),
        .pkt_hdr(pkt_hdr), .pkt_payload(pkt_payload), .pkt_perr(pkt_perr),
        .req_ovf(req_ovf)
`ifdef NCU_SII_PERR_DROP_EN
        , .perr_drop_cnt(perr_drop_cnt)
`endif
    );

    always #5 iol2clk = ~iol2clk;
    always @(posedge iol2clk) cyc <= cyc + 1;

    function automatic logic [31:0] exp_hdr(input int k);
        return 32'hA5A50001 + 32'(k);
    endfunction

    function automatic logic [31:0] exp_word(input int k, input int n);
        logic [31:0] base;
        base = 32'h11111111;
        return (base * 32'(n + 1)) ^ {8'(k), 24'h000000};
    endfunction

    function automatic logic [127:0] exp_pl(input int k);
        return {exp_word(k, 3), exp_word(k, 2), exp_word(k, 1), exp_word(k, 0)};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_word(input logic [31:0] d, input bit flip);
        sii_ncu_data    = d;
        sii_ncu_dparity = {^d[31:16], ^d[15:0]} ^ (flip ? flip_mask : 2'b00);
    endtask

    task automatic pulse_req(input int n);
        for (int i = 0; i < n; i++) begin
            sii_ncu_req = 1'b1;
            @(negedge iol2clk);
        end
        sii_ncu_req = 1'b0;
    endtask

    task automatic wait_gnt(output bit seen, input int max_cyc);
        seen = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            if (ncu_sii_gnt === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge iol2clk);
        end
    endtask

    // SII side: answer every grant with header then four payload words.
    initial begin : sii_model
        int k;
        sii_ncu_data = 32'h0;
        sii_ncu_dparity = 2'b00;
        forever begin
            @(negedge iol2clk);
            sii_ncu_data = 32'hDEADBEEF;
            sii_ncu_dparity = 2'b00;
            if (ncu_sii_gnt === 1'b1) begin
                k = gnt_seen;
                gnt_cyc[k] = cyc;
                gnt_seen++;
                repeat (G2H) @(negedge iol2clk);
                drive_word(exp_hdr(k), (k == flip_pkt) && (flip_sel == 0));
                for (int n = 0; n < 4; n++) begin
                    @(negedge iol2clk);
                    drive_word(exp_word(k, n), (k == flip_pkt) && (flip_sel == n + 1));
                end
            end
        end
    end

    // Record every packet the core side accepts.
    initial begin : pop_mon
        pop_t e;
        forever begin
            @(negedge iol2clk);
            #1;
            if (pkt_vld === 1'b1 && pkt_rdy === 1'b1) begin
                e.hdr = pkt_hdr;
                e.pl = pkt_payload;
                e.perr = pkt_perr;
                popped.push_back(e);
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int c0, g0, p0;
        bit seen, saw_gnt, saw_vld;
        rst = 1'b1;
        sii_ncu_req = 1'b0;
        pkt_rdy = 1'b0;
        repeat (2) @(negedge iol2clk);
        check("rst_gnt", ncu_sii_gnt, 0);
        check("rst_vld", pkt_vld, 0);
        check("rst_perr", pkt_perr, 0);
        check("rst_ovf", req_ovf, 0);
        check("rst_hdr", pkt_hdr, 0);
        check("rst_payload", pkt_payload, 0);
        rst = 1'b0;
        @(negedge iol2clk);

        // Single packet
        c0 = cyc;
        pulse_req(1);
        repeat (8) @(negedge iol2clk);
        check("single_gnt_count", gnt_seen, 1);
        check("single_gnt_cycle", gnt_cyc[0], c0 + 1);
        check("single_vld_c9", pkt_vld, 1);
        check("single_hdr", pkt_hdr, 32'hA5A50001);
        check("single_payload", pkt_payload, 128'h44444444_33333333_22222222_11111111);
        check("single_perr", pkt_perr, 0);
        pkt_rdy = 1'b1;
        @(negedge iol2clk);
        pkt_rdy = 1'b0;
        check("single_pop_empty", pkt_vld, 0);

        // Back-to-back
        pkt_rdy = 1'b1;
        g0 = gnt_seen;
        p0 = popped.size();
        pulse_req(3);
        repeat (30) @(negedge iol2clk);
        check("b2b_gnt_count", gnt_seen - g0, 3);
        check("b2b_spacing_a", gnt_cyc[g0 + 1] - gnt_cyc[g0], G2H + 5);
        check("b2b_spacing_b", gnt_cyc[g0 + 2] - gnt_cyc[g0 + 1], G2H + 5);
        check("b2b_pop_count", popped.size() - p0, 3);
        for (int i = 0; i < 3; i++) begin
            if (p0 + i < popped.size()) begin
                check("b2b_hdr", popped[p0 + i].hdr, exp_hdr(g0 + i));
                check("b2b_payload", popped[p0 + i].pl, exp_pl(g0 + i));
            end
        end

        // Parity: PL2 upper-half flip, then header flip
        g0 = gnt_seen;
        p0 = popped.size();
        flip_pkt = g0;
        flip_sel = 3;
        flip_mask = 2'b10;
        pulse_req(1);
        repeat (14) @(negedge iol2clk);
        flip_pkt = g0 + 1;
        flip_sel = 0;
        flip_mask = 2'b11;
        pulse_req(1);
        repeat (14) @(negedge iol2clk);
        flip_pkt = -1;
`ifdef NCU_SII_PERR_DROP_EN
        check("par_pop_count", popped.size() - p0, 1);
        if (popped.size() > p0) begin
            check("par_hdr_kept", popped[p0].hdr, exp_hdr(g0 + 1));
            check("par_hdrflip_perr", popped[p0].perr, 0);
        end
        check("par_drop_cnt", perr_drop_cnt, 1);
`else
        check("par_pop_count", popped.size() - p0, 2);
        if (popped.size() > p0 + 1) begin
            check("par_pl2_hdr", popped[p0].hdr, exp_hdr(g0));
            check("par_pl2_perr", popped[p0].perr, 1);
            check("par_hdrflip_hdr", popped[p0 + 1].hdr, exp_hdr(g0 + 1));
            check("par_hdrflip_perr", popped[p0 + 1].perr, 0);
        end
`endif

        // Reset in the middle of a packet
        pkt_rdy = 1'b0;
        g0 = gnt_seen;
        pulse_req(2);
        wait_gnt(seen, 20);
        check("rstmid_second_gnt", seen, 1);
        repeat (4) @(negedge iol2clk);
        check("rstmid_pre_vld", pkt_vld, 1);
        rst = 1'b1;
        #1;
        check("rstmid_gnt", ncu_sii_gnt, 0);
        check("rstmid_vld", pkt_vld, 0);
        check("rstmid_hdr", pkt_hdr, 0);
        check("rstmid_payload", pkt_payload, 0);
        check("rstmid_perr", pkt_perr, 0);
        repeat (2) @(negedge iol2clk);
        rst = 1'b0;
        saw_gnt = 1'b0;
        saw_vld = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge iol2clk);
            if (ncu_sii_gnt !== 1'b0) saw_gnt = 1'b1;
            if (pkt_vld !== 1'b0) saw_vld = 1'b1;
        end
        check("rstmid_no_gnt", saw_gnt, 0);
        check("rstmid_no_vld", saw_vld, 0);
        pulse_req(1);
        check("rstmid_new_gnt", ncu_sii_gnt, 1);
        pkt_rdy = 1'b1;
        repeat (12) @(negedge iol2clk);
        check("rstmid_new_hdr", popped[$].hdr, exp_hdr(g0 + 2));
        check("rstmid_new_payload", popped[$].pl, exp_pl(g0 + 2));

        // Backpressure / full
        pkt_rdy = 1'b0;
        g0 = gnt_seen;
        pulse_req(6);
        repeat (50) @(negedge iol2clk);
        check("bp_gnt_count", gnt_seen - g0, 4);
        check("bp_req_cnt", dut.req_cnt_r, 2);
        check("bp_vld", pkt_vld, 1);
        pkt_rdy = 1'b1;
        @(negedge iol2clk);
        pkt_rdy = 1'b0;
        wait_gnt(seen, 2);
        check("bp_fifth_gnt", seen, 1);
        repeat (15) @(negedge iol2clk);
        check("bp_req_cnt_after", dut.req_cnt_r, 1);

        // Overflow with FIFO full
        g0 = gnt_seen;
        pulse_req(16);
        check("ovf_req_cnt", dut.req_cnt_r, 15);
        check("ovf_flag", req_ovf, 1);
        repeat (5) @(negedge iol2clk);
        check("ovf_req_cnt_hold", dut.req_cnt_r, 15);
        check("ovf_flag_sticky", req_ovf, 1);
        check("ovf_no_gnt", gnt_seen - g0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
